// File: rtl/coeff_unpack_if.sv
// Handshake bundle between the ciphertext byte source, the unpacker and decompress.
// master drives start/d/bytes/cready; slave is the unpacker.
interface coeff_unpack_if;
  logic        start;
  logic [3:0]  d;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [11:0] coeff;
  logic        cvalid;
  logic        cready;
  logic        last;
  logic        done;
  logic        err;

  modport master (
    output start, d, data, valid, cready,
    input  ready, coeff, cvalid, last, done, err
  );

  modport slave (
    input  start, d, data, valid, cready,
    output ready, coeff, cvalid, last, done, err
  );
endinterface

// File: rtl/coeff_unpack.sv
// Kyber ByteDecode_d unpacker: packed bytes in, d-bit coefficients out LSB-first.
// Optional macro UNPACK_D12_EN enables d=12 with reduction of raw values >= KYBER_Q.
module coeff_unpack #(
  parameter int unsigned N_COEFF = 256,
  parameter int unsigned BUF_W   = 24,
  parameter int unsigned KYBER_Q = 3329
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  coeff_unpack_if.slave bus
);
  localparam int unsigned COEFF_W = 12;
  localparam int unsigned D_W     = 4;
  localparam int unsigned CNT_W   = $clog2(BUF_W + 1);
  localparam int unsigned IDX_W   = $clog2(N_COEFF + 1);
  localparam int unsigned BYTES_W = $clog2(N_COEFF * COEFF_W / 8 + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_n;
  logic [BUF_W-1:0]     buffer, buffer_n, shifted;
  logic [CNT_W-1:0]     bitcnt, bitcnt_n, avail;
  logic [IDX_W-1:0]     coeff_cnt, coeff_cnt_n;
  logic [BYTES_W-1:0]   byte_cnt, byte_cnt_n;
  logic [D_W-1:0]       d_reg, d_reg_n;
  logic                 ready_q, ready_n;
  logic                 cvalid_q, cvalid_n;
  logic [COEFF_W-1:0]   coeff_q, coeff_n, field;
  logic                 last_q, last_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;
  logic                 coeff_hs, byte_hs;

  function automatic logic d_legal(input logic [D_W-1:0] dv);
    case (dv)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: d_legal = 1'b1;
`ifdef UNPACK_D12_EN
      4'd12:                          d_legal = 1'b1;
`endif
      default:                        d_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [BYTES_W-1:0] byte_total(input logic [D_W-1:0] dv);
    byte_total = BYTES_W'((N_COEFF / 8) * 32'(dv));
  endfunction

  // Next-state: shift out a consumed coefficient first, then append an accepted byte above it
  always_comb begin
    state_n     = state;
    buffer_n    = buffer;
    bitcnt_n    = bitcnt;
    coeff_cnt_n = coeff_cnt;
    byte_cnt_n  = byte_cnt;
    d_reg_n     = d_reg;
    done_n      = 1'b0;
    err_n       = 1'b0;
    coeff_n     = '0;

    coeff_hs = (state == RUN) && cvalid_q && bus.cready;
    byte_hs  = (state == RUN) && ready_q && bus.valid;
    shifted  = coeff_hs ? (buffer >> d_reg) : buffer;
    avail    = coeff_hs ? (bitcnt - CNT_W'(d_reg)) : bitcnt;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (d_legal(bus.d)) begin
            state_n     = RUN;
            buffer_n    = '0;
            bitcnt_n    = '0;
            coeff_cnt_n = '0;
            byte_cnt_n  = '0;
            d_reg_n     = bus.d;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        buffer_n = byte_hs ? (shifted | (BUF_W'(bus.data) << avail)) : shifted;
        bitcnt_n = byte_hs ? (avail + CNT_W'(8)) : avail;
        if (byte_hs) byte_cnt_n = byte_cnt + BYTES_W'(1);
        if (coeff_hs) begin
          coeff_cnt_n = coeff_cnt + IDX_W'(1);
          if (coeff_cnt == IDX_W'(N_COEFF - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Handshake flags are precomputed from next state so outputs come straight off flops
    ready_n  = (state_n == RUN) && (bitcnt_n <= CNT_W'(BUF_W - 8)) &&
               (byte_cnt_n < byte_total(d_reg_n));
    cvalid_n = (state_n == RUN) && (bitcnt_n >= CNT_W'(d_reg_n));
    last_n   = cvalid_n && (coeff_cnt_n == IDX_W'(N_COEFF - 1));
    field    = buffer_n[COEFF_W-1:0] & ((COEFF_W'(1) << d_reg_n) - COEFF_W'(1));
    if (cvalid_n) coeff_n = field;
`ifdef UNPACK_D12_EN
    if (cvalid_n && (d_reg_n == D_W'(12)) && (field >= COEFF_W'(KYBER_Q)))
      coeff_n = field - COEFF_W'(KYBER_Q);
`endif
  end

`ifndef UNPACK_D12_EN
  logic [31:0] unused_kyber_q;
  assign unused_kyber_q = KYBER_Q;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      buffer    <= '0;
      bitcnt    <= '0;
      coeff_cnt <= '0;
      byte_cnt  <= '0;
      d_reg     <= '0;
      ready_q   <= 1'b0;
      cvalid_q  <= 1'b0;
      coeff_q   <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      buffer    <= buffer_n;
      bitcnt    <= bitcnt_n;
      coeff_cnt <= coeff_cnt_n;
      byte_cnt  <= byte_cnt_n;
      d_reg     <= d_reg_n;
      ready_q   <= ready_n;
      cvalid_q  <= cvalid_n;
      coeff_q   <= coeff_n;
      last_q    <= last_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.cvalid = cvalid_q;
  assign bus.coeff  = coeff_q;
  assign bus.last   = last_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_coeff_unpack.sv
// Bench for coeff_unpack: start-legality table, directed byte streams and
// randomized polynomials checked against a bit-extraction reference model.
module tb_coeff_unpack;
  localparam int unsigned N = 256;
  localparam int unsigned Q = 3329;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   bytes_taken;

  logic [7:0]  tx [0:383];
  logic [11:0] got [$];

  coeff_unpack_if bus ();

  coeff_unpack #(.N_COEFF(N), .BUF_W(24), .KYBER_Q(Q)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       err;
  } start_vec_t;

  start_vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Coefficient k is stream bits [k*d +: d], byte bit 0 first
  function automatic logic [11:0] model(input int d, input int k);
    int v;
    int pos;
    v = 0;
    for (int b = 0; b < d; b++) begin
      pos = k * d + b;
      v += int'(tx[pos / 8][pos % 8]) << b;
    end
    if (d == 12 && v >= int'(Q)) v -= int'(Q);
    return 12'(v);
  endfunction

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.d      = 4'd0;
    bus.data   = 8'd0;
    bus.valid  = 1'b0;
    bus.cready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] d, output logic e, output logic r);
    bus.start = 1'b1;
    bus.d     = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.d     = 4'd0;
    e = bus.err;
    r = bus.ready;
  endtask

  // Drives one polynomial from tx[]; p_cready < 0 toggles cready every cycle
  task automatic run_poly(input int d, input int p_valid, input int p_cready,
                          input int stop_at, input int inject_at, input int stall_cyc,
                          input string tag);
    int          total;
    int          k;
    int          bi;
    int          cyc;
    logic        stalled;
    logic [11:0] hold_c;
    logic        hold_l;
    logic        vset;
    logic        cset;
    total   = int'(N) * d / 8;
    k       = 0;
    bi      = 0;
    cyc     = 0;
    stalled = 1'b0;
    hold_c  = '0;
    hold_l  = 1'b0;
    got.delete();
    while (k < stop_at) begin
      if (cyc > 20000) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: got %0d coeffs expected %0d", tag, k, stop_at);
        break;
      end
      if (stalled) begin
        check({tag, " stall cvalid"}, 32'(bus.cvalid), 32'd1);
        check({tag, " stall coeff"}, 32'(bus.coeff), 32'(hold_c));
        check({tag, " stall last"}, 32'(bus.last), 32'(hold_l));
      end
      if (bi == total) check({tag, " refuse extra byte"}, 32'(bus.ready), 32'd0);
      check({tag, " no early done"}, 32'(bus.done), 32'd0);
      if (stall_cyc > 0 && cyc == stall_cyc) begin
        check({tag, " bytes to fill buffer"}, 32'(bi), 32'd3);
        check({tag, " ready low when full"}, 32'(bus.ready), 32'd0);
      end

      if (cyc < stall_cyc) begin
        vset = 1'b1;
        cset = 1'b0;
      end else begin
        vset = ($urandom_range(99) < 32'(p_valid));
        cset = (p_cready < 0) ? ((cyc % 2) == 1) : ($urandom_range(99) < 32'(p_cready));
      end
      bus.valid  = vset;
      bus.data   = (bi < total) ? tx[bi] : 8'hEE;
      bus.cready = cset;
      bus.start  = (cyc == inject_at);
      bus.d      = (cyc == inject_at) ? 4'd5 : 4'd0;

      if (bus.cvalid && cset) begin
        check({tag, " coeff"}, 32'(bus.coeff), 32'(model(d, k)));
        check({tag, " last"}, 32'(bus.last), 32'(k == int'(N) - 1));
        got.push_back(bus.coeff);
        k++;
      end
      if (bus.ready && vset && bi < total) bi++;
      stalled = bus.cvalid && !cset;
      hold_c  = bus.coeff;
      hold_l  = bus.last;
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    bytes_taken = bi;
    if (stop_at >= int'(N)) begin
      check({tag, " done pulse"}, 32'(bus.done), 32'd1);
      check({tag, " idle cvalid"}, 32'(bus.cvalid), 32'd0);
      check({tag, " idle ready"}, 32'(bus.ready), 32'd0);
      check({tag, " bytes consumed"}, 32'(bi), 32'(total));
      @(negedge clk);
      check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic        e;
    logic        r;
    int          dl;
    int          legal [5];

    for (int i = 0; i < 16; i++) begin
      tbl[i].d   = 4'(i);
      tbl[i].err = 1'b1;
    end
    tbl[1].err  = 1'b0;
    tbl[4].err  = 1'b0;
    tbl[5].err  = 1'b0;
    tbl[10].err = 1'b0;
    tbl[11].err = 1'b0;
`ifdef UNPACK_D12_EN
    tbl[12].err = 1'b0;
`endif

    // Reset state
    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd0);
    check("reset cvalid", 32'(bus.cvalid), 32'd0);
    check("reset coeff", 32'(bus.coeff), 32'd0);
    check("reset last", 32'(bus.last), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Start legality table
    for (int i = 0; i < 16; i++) begin
      do_reset();
      do_start(tbl[i].d, e, r);
      check($sformatf("start d=%0d err", tbl[i].d), 32'(e), 32'(tbl[i].err));
      check($sformatf("start d=%0d ready", tbl[i].d), 32'(r), 32'(!tbl[i].err));
      if (tbl[i].err) begin
        @(negedge clk);
        check($sformatf("start d=%0d err pulse", tbl[i].d), 32'(bus.err), 32'd0);
        check($sformatf("start d=%0d stays idle", tbl[i].d), 32'(bus.ready), 32'd0);
      end
    end
    do_reset();

    // d=4 counting nibbles, full rate
    for (int j = 0; j < 128; j++) tx[j] = {4'((2 * j + 2) % 16), 4'((2 * j + 1) % 16)};
    do_start(4'd4, e, r);
    run_poly(4, 100, 100, N, -1, 0, "d4");
    check("d4 coeff0", 32'(got[0]), 32'd1);
    check("d4 coeff1", 32'(got[1]), 32'd2);
    check("d4 coeff255", 32'(got[255]), 32'd0);

    // d=11 with toggling cready and an ignored mid-stream start
    for (int j = 0; j < 352; j++) tx[j] = (j % 2 == 0) ? 8'hFF : 8'h07;
    do_start(4'd11, e, r);
    run_poly(11, 100, -1, N, 30, 0, "d11");
    check("d11 coeff0", 32'(got[0]), 32'h7FF);
    check("d11 bytes", 32'(bytes_taken), 32'd352);

    // d=1 with initial backpressure filling the buffer
    for (int j = 0; j < 32; j++) tx[j] = 8'hA5;
    do_start(4'd1, e, r);
    run_poly(1, 100, 100, N, -1, 8, "d1");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      check($sformatf("d1 coeff%0d", i), 32'(got[i]), 32'(pat[i]));
    end
    check("d1 bytes", 32'(bytes_taken), 32'd32);

    // Reset mid-polynomial, then a clean d=5 decode
    for (int j = 0; j < 384; j++) tx[j] = 8'($urandom);
    do_start(4'd10, e, r);
    run_poly(10, 80, 80, 50, -1, 0, "d10 partial");
    rstn = 1'b0;
    #1;
    check("midreset ready", 32'(bus.ready), 32'd0);
    check("midreset cvalid", 32'(bus.cvalid), 32'd0);
    check("midreset coeff", 32'(bus.coeff), 32'd0);
    check("midreset last", 32'(bus.last), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 384; j++) tx[j] = 8'($urandom);
    do_start(4'd5, e, r);
    check("d5 after reset ready", 32'(r), 32'd1);
    run_poly(5, 90, 90, N, -1, 0, "d5");

    // d=12 with modular correction
`ifdef UNPACK_D12_EN
    for (int j = 0; j < 384; j++) tx[j] = (j % 3 == 0) ? 8'h01 : ((j % 3 == 1) ? 8'hD0 : 8'hFF);
    do_start(4'd12, e, r);
    run_poly(12, 100, 100, N, -1, 0, "d12");
    check("d12 coeff0", 32'(got[0]), 32'h001);
    check("d12 coeff1", 32'(got[1]), 32'h2FC);
`else
    do_start(4'd12, e, r);
    check("d12 disabled err", 32'(e), 32'd1);
    check("d12 disabled ready", 32'(r), 32'd0);
    @(negedge clk);
`endif

    // Randomized polynomials
    legal[0] = 1; legal[1] = 4; legal[2] = 5; legal[3] = 10; legal[4] = 11;
    for (int it = 0; it < 6; it++) begin
      dl = legal[$urandom_range(4)];
      for (int j = 0; j < 384; j++) tx[j] = 8'($urandom);
      do_start(4'(dl), e, r);
      check($sformatf("rand%0d start ready", it), 32'(r), 32'd1);
      run_poly(dl, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), N, -1, 0,
               $sformatf("rand%0d d%0d", it, dl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
